// File: rtl/usb_defs.sv
// usb_defs: USB constants shared by the data-packet transmitter and the receive-side CRC checker.
// Holds the PID bytes, the CRC16 parameters and the transmitter state encoding.
package usb_defs;

    localparam logic [7:0]  PID_DATA0       = 8'hC3;
    localparam logic [7:0]  PID_DATA1       = 8'h4B;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_FETCH,
        S_WAIT,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_DONE
    } txState_e;

    function automatic logic [7:0] pidFor(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: combinational byte-wise CRC16 update (reflected polynomial, LSB first).
// Shared between the data transmitter and the receive-side CRC checker.
module usb_crc16
    import usb_defs::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] acc;

    always_comb begin
        acc = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            acc = acc[0] ? ((acc >> 1) ^ CRC16_POLY_REFL) : (acc >> 1);
        end
    end

    assign crc_o = acc;

endmodule

// File: rtl/usb_data_tx.sv
// usb_data_tx: builds IN data packets (PID, up to MAX_PKT queue bytes, CRC16) onto a valid/ready byte stream.
// Define USB_DATA_TX_RETRY_EN to add the retry input and a replay buffer for resending the last packet.
module usb_data_tx
    import usb_defs::*;
#(
    parameter int MAX_PKT = 8,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_toggle,
`ifdef USB_DATA_TX_RETRY_EN
    input  logic             retry,
`endif
    output logic             usb_send_queue_r_en,
    input  logic [7:0]       usb_send_queue_data_out,
    input  logic             usb_send_queue_empty,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_bytes,
    output logic             pkt_short
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT);

    txState_e         state_q;
    logic [CNT_W-1:0] byteCnt_q;
    logic [15:0]      crc_q;
    logic [15:0]      crcNext_d;
    logic [7:0]       fetchByte_d;
    logic             fetchMore_d;

`ifdef USB_DATA_TX_RETRY_EN
    localparam int IDX_W = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

    logic             replay_q;
    logic             lastToggle_q;
    logic [CNT_W-1:0] lastCnt_q;
    logic [7:0]       replayBuf_q [MAX_PKT];
    logic [IDX_W-1:0] bufIdx;

    assign bufIdx = byteCnt_q[IDX_W-1:0];

    // A replay walks the saved payload instead of the queue, for exactly the last packet's length.
    assign fetchMore_d = replay_q ? (byteCnt_q != lastCnt_q)
                                  : ((byteCnt_q != MAX_CNT) && !usb_send_queue_empty);
    assign fetchByte_d = replay_q ? replayBuf_q[bufIdx] : usb_send_queue_data_out;
    assign usb_send_queue_r_en = (state_q == S_FETCH) && fetchMore_d && !replay_q;

    always_ff @(posedge clk) begin
        if (state_q == S_WAIT && !replay_q) begin
            replayBuf_q[bufIdx] <= usb_send_queue_data_out;
        end
    end
`else
    assign fetchMore_d = (byteCnt_q != MAX_CNT) && !usb_send_queue_empty;
    assign fetchByte_d = usb_send_queue_data_out;
    assign usb_send_queue_r_en = (state_q == S_FETCH) && fetchMore_d;
`endif

    usb_crc16 u_crc (
        .crc_i  (crc_q),
        .data_i (fetchByte_d),
        .crc_o  (crcNext_d)
    );

    // tx_data doubles as the holding register, so it only changes when a byte is accepted or loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            byteCnt_q <= '0;
            crc_q     <= CRC16_INIT;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_bytes <= '0;
            pkt_short <= 1'b0;
`ifdef USB_DATA_TX_RETRY_EN
            replay_q     <= 1'b0;
            lastToggle_q <= 1'b0;
            lastCnt_q    <= '0;
`endif
        end else begin
            pkt_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
`ifdef USB_DATA_TX_RETRY_EN
                        replay_q <= retry;
                        if (!retry) begin
                            lastToggle_q <= data_toggle;
                        end
                        tx_data <= pidFor(retry ? lastToggle_q : data_toggle);
`else
                        tx_data <= pidFor(data_toggle);
`endif
                        byteCnt_q <= '0;
                        crc_q     <= CRC16_INIT;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        state_q   <= S_PID;
                    end
                end
                S_PID, S_DATA: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetchMore_d) begin
                        state_q <= S_WAIT;
                    end else begin
                        tx_data  <= ~crc_q[7:0];
                        tx_valid <= 1'b1;
                        state_q  <= S_CRC_LO;
                    end
                end
                S_WAIT: begin
                    crc_q     <= crcNext_d;
                    byteCnt_q <= byteCnt_q + 1'b1;
                    tx_data   <= fetchByte_d;
                    tx_valid  <= 1'b1;
                    state_q   <= S_DATA;
                end
                S_CRC_LO: begin
                    if (tx_ready) begin
                        tx_data <= ~crc_q[15:8];
                        tx_last <= 1'b1;
                        state_q <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        tx_last   <= 1'b0;
                        pkt_done  <= 1'b1;
                        pkt_bytes <= byteCnt_q;
                        pkt_short <= (byteCnt_q < MAX_CNT);
`ifdef USB_DATA_TX_RETRY_EN
                        lastCnt_q <= byteCnt_q;
`endif
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_data_tx.sv
// tb_usb_data_tx: randomized bench for usb_data_tx, checked against a packet-level model of the framing rules.
// Honours USB_DATA_TX_RETRY_EN to also exercise the replay path.
module tb_usb_data_tx;

    localparam int MAX_PKT = 8;
    localparam int CNT_W   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             data_toggle;
`ifdef USB_DATA_TX_RETRY_EN
    logic             retry = 1'b0;
`endif
    logic             usb_send_queue_r_en;
    logic [7:0]       usb_send_queue_data_out = 8'h00;
    logic             usb_send_queue_empty = 1'b1;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic             tx_last;
    logic             busy;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_bytes;
    logic             pkt_short;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    logic [7:0]  sendQ[$];
    logic [7:0]  expBytes[$];
    logic [7:0]  gotLog[$];
    logic [7:0]  lastPayload[$];
    logic        lastToggle = 1'b0;
    int          expRd = 0;
    int          gotBase = 0;
    int unsigned expPktBytes = 0;
    logic        expShort = 1'b0;
    int unsigned readyProb = 100;
    int unsigned rdCount = 0;
    int unsigned rdBase = 0;
    int unsigned expReads = 0;
    int unsigned doneCount = 0;
    int unsigned doneBase = 0;
    logic        rdPend = 1'b0;
    logic        prevStall = 1'b0;
    logic        prevLast = 1'b0;
    logic        prevRen = 1'b0;
    logic [7:0]  prevData = 8'h00;

    usb_data_tx #(.MAX_PKT(MAX_PKT), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .data_toggle             (data_toggle),
`ifdef USB_DATA_TX_RETRY_EN
        .retry                   (retry),
`endif
        .usb_send_queue_r_en     (usb_send_queue_r_en),
        .usb_send_queue_data_out (usb_send_queue_data_out),
        .usb_send_queue_empty    (usb_send_queue_empty),
        .tx_data                 (tx_data),
        .tx_valid                (tx_valid),
        .tx_ready                (tx_ready),
        .tx_last                 (tx_last),
        .busy                    (busy),
        .pkt_done                (pkt_done),
        .pkt_bytes               (pkt_bytes),
        .pkt_short               (pkt_short)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-serial CRC16 over a byte list, returning the complemented value that goes on the wire.
    function automatic logic [15:0] crcRef(input logic [7:0] b[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = r[0] ^ b[i][k];
                r  = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        end
        return ~r;
    endfunction

    // Queue model: a read seen during a cycle delivers the head byte for the following cycle.
    always @(negedge clk) rdPend = usb_send_queue_r_en;
    always @(posedge clk) begin
        #1;
        if (rdPend && sendQ.size() != 0) begin
            usb_send_queue_data_out = sendQ.pop_front();
            rdCount++;
        end
        usb_send_queue_empty = (sendQ.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        tx_ready = ($urandom_range(99, 0) < readyProb);
    end

    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
            prevRen   = 1'b0;
            expRd     = expBytes.size();
        end else begin
            if (prevStall) begin
                checkOutput("stall tx_data", 32'(tx_data), 32'(prevData));
                checkOutput("stall valid/last", 32'({tx_valid, tx_last}), 32'({1'b1, prevLast}));
            end
            if (usb_send_queue_r_en) begin
                checkOutput("r_en with empty queue", 32'(sendQ.size() == 0), 32'(0));
                checkOutput("r_en single pulse", 32'(prevRen), 32'(0));
            end
            if (tx_valid && tx_ready) begin
                gotLog.push_back(tx_data);
                checkOutput("byte expected", 32'(expRd < expBytes.size()), 32'(1));
                if (expRd < expBytes.size()) begin
                    checkOutput("tx_data", 32'(tx_data), 32'(expBytes[expRd]));
                    expRd++;
                    checkOutput("tx_last", 32'(tx_last), 32'(expRd == expBytes.size()));
                end
            end
            if (pkt_done) begin
                doneCount++;
                checkOutput("bytes left at done", 32'(expBytes.size() - expRd), 32'(0));
                checkOutput("pkt_bytes", 32'(pkt_bytes), 32'(expPktBytes));
                checkOutput("pkt_short", 32'(pkt_short), 32'(expShort));
            end
            prevStall = tx_valid && !tx_ready;
            prevData  = tx_data;
            prevLast  = tx_last;
            prevRen   = usb_send_queue_r_en;
        end
    end

    task automatic loadQueue(input int n);
        for (int i = 0; i < n; i++) sendQ.push_back(8'($urandom_range(255, 0)));
    endtask

    task automatic beginPacket(input logic toggle, input logic doRetry, input int unsigned prob);
        logic [7:0]  pay[$];
        logic [15:0] c;
        logic        tg;
        int          n;
        readyProb = prob;
        pay = {};
        if (doRetry) begin
            pay      = lastPayload;
            tg       = lastToggle;
            expReads = 0;
        end else begin
            n = (sendQ.size() < MAX_PKT) ? sendQ.size() : MAX_PKT;
            for (int i = 0; i < n; i++) pay.push_back(sendQ[i]);
            tg       = toggle;
            expReads = n;
        end
        c = crcRef(pay);
        expBytes.push_back(tg ? 8'h4B : 8'hC3);
        foreach (pay[i]) expBytes.push_back(pay[i]);
        expBytes.push_back(c[7:0]);
        expBytes.push_back(c[15:8]);
        expPktBytes = pay.size();
        expShort    = (pay.size() < MAX_PKT);
        lastPayload = pay;
        lastToggle  = tg;
        gotBase  = gotLog.size();
        doneBase = doneCount;
        rdBase   = rdCount;
        @(posedge clk);
        #1;
        data_toggle = toggle;
        start = 1'b1;
`ifdef USB_DATA_TX_RETRY_EN
        retry = doRetry;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finishPacket();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #2;
            if (doneCount != doneBase) break;
        end
        checkOutput("pkt_done seen", 32'(doneCount - doneBase), 32'(1));
        checkOutput("queue reads", rdCount - rdBase, expReads);
        @(posedge clk);
        #1;
        checkOutput("busy after packet", 32'(busy), 32'(0));
    endtask

    task automatic applyStimulus(input logic toggle, input logic doRetry, input int unsigned prob);
        beginPacket(toggle, doRetry, prob);
        finishPacket();
    endtask

    initial begin
        logic [7:0]  ascii[$];
        logic [7:0]  none[$];
        int unsigned rd0;
        rst = 1'b1;
        start = 1'b0;
        data_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("outputs in reset", 32'({tx_data, pkt_bytes, usb_send_queue_r_en, tx_valid,
                    tx_last, busy, pkt_done, pkt_short}), 32'(0));
        rst = 1'b0;

        ascii = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        none = {};
        checkOutput("model crc of 123456789", 32'(crcRef(ascii)), 32'h0000B4C8);
        checkOutput("model crc of nothing", 32'(crcRef(none)), 32'h00000000);

`ifdef USB_DATA_TX_RETRY_EN
        $display("[TB] retry before any packet");
        applyStimulus(1'b1, 1'b1, 100);
        checkOutput("early retry length", 32'(gotLog.size() - gotBase), 32'(3));
        checkOutput("early retry pid", 32'(gotLog[gotBase]), 32'h000000C3);
`endif

        $display("[TB] descriptor packet, DATA1");
        sendQ = {8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08};
        applyStimulus(1'b1, 1'b0, 100);
        checkOutput("descriptor length", 32'(gotLog.size() - gotBase), 32'(11));
        checkOutput("descriptor pid", 32'(gotLog[gotBase]), 32'h0000004B);
        checkOutput("descriptor byte 8", 32'(gotLog[gotBase + 8]), 32'h00000008);
        checkOutput("descriptor pkt_bytes", 32'(pkt_bytes), 32'(8));
        checkOutput("descriptor pkt_short", 32'(pkt_short), 32'(0));

        $display("[TB] zero-length packet, DATA0");
        applyStimulus(1'b0, 1'b0, 100);
        checkOutput("zlp length", 32'(gotLog.size() - gotBase), 32'(3));
        checkOutput("zlp bytes", 32'({gotLog[gotBase], gotLog[gotBase + 1], gotLog[gotBase + 2]}),
                    32'h00C30000);
        checkOutput("zlp pkt_short", 32'(pkt_short), 32'(1));

        $display("[TB] ten bytes split across two packets");
        loadQueue(10);
        rd0 = rdCount;
        applyStimulus(1'b0, 1'b0, 100);
        checkOutput("split first pkt_short", 32'(pkt_short), 32'(0));
        applyStimulus(1'b1, 1'b0, 100);
        checkOutput("split second pkt_bytes", 32'(pkt_bytes), 32'(2));
        checkOutput("split second pid", 32'(gotLog[gotBase]), 32'h0000004B);
        checkOutput("split total reads", rdCount - rd0, 32'(10));

        $display("[TB] random packets with 50%% tx_ready");
        for (int i = 0; i < 8; i++) begin
            loadQueue($urandom_range(12, 0));
            applyStimulus(1'($urandom_range(1, 0)), 1'b0, 50);
        end

        $display("[TB] reset in the middle of a packet");
        sendQ = {};
        repeat (2) @(posedge clk);
        loadQueue(10);
        beginPacket(1'b0, 1'b0, 100);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (tx_valid && !tx_last && (gotLog.size() - gotBase) >= 3) break;
        end
        checkOutput("reached payload before reset", 32'((gotLog.size() - gotBase) >= 3), 32'(1));
        rst = 1'b1;
        #1;
        checkOutput("outputs at async reset", 32'({tx_data, pkt_bytes, usb_send_queue_r_en, tx_valid,
                    tx_last, busy, pkt_done, pkt_short}), 32'(0));
        lastPayload = {};
        lastToggle  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 100);

`ifdef USB_DATA_TX_RETRY_EN
        $display("[TB] retry of a three-byte packet");
        sendQ = {};
        repeat (2) @(posedge clk);
        loadQueue(3);
        applyStimulus(1'b1, 1'b0, 100);
        loadQueue(4);
        applyStimulus(1'b0, 1'b1, 50);
        checkOutput("retry length", 32'(gotLog.size() - gotBase), 32'(6));
        checkOutput("retry pid", 32'(gotLog[gotBase]), 32'h0000004B);
        checkOutput("queue untouched by retry", 32'(sendQ.size()), 32'(4));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/usb_data_tx.md
Name: usb_data_tx

Overview:
- IN data-packet builder directly downstream of the control/setup stage.
- Drains usb_send_queue in packets of at most MAX_PKT bytes. Each packet is framed as PID (DATA0/DATA1 from the toggle input), payload, then CRC16.
- Streams the framed bytes over a valid/ready byte interface to the bit-level serializer (bit stuffing/NRZI).

Parameters:
- MAX_PKT, 8, maximum payload bytes per packet (8 for low speed, up to 64).
- CNT_W, 7, width of the byte counter; must satisfy 2^CNT_W > MAX_PKT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: IN token for this endpoint accepted, build one packet
- data_toggle  in  1  0 selects DATA0, 1 selects DATA1; sampled on start
- usb_send_queue_r_en  out  1  queue read strobe; data valid on the following cycle
- usb_send_queue_data_out  in  8  queue read data
- usb_send_queue_empty  in  1  queue empty flag
- tx_data  out  8  byte to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts byte when tx_valid && tx_ready
- tx_last  out  1  marks the final CRC byte
- busy  out  1  packet in progress
- pkt_done  out  1  one-cycle pulse after the last byte is accepted
- pkt_bytes  out  CNT_W  payload byte count of the last packet
- pkt_short  out  1  last packet had fewer than MAX_PKT bytes (ends the control data stage)

Behaviour:
- Reset (asynchronous, any state): all outputs 0, FSM in IDLE, CRC register = 16'hFFFF.
- FSM states: IDLE, PID, FETCH, WAIT, DATA, CRC_LO, CRC_HI, DONE.
- IDLE:
  - On start, latch data_toggle, clear the counter, set CRC to 16'hFFFF, assert busy, go to PID.
  - start while busy is ignored.
- PID:
  - tx_data = 8'hC3 (DATA0) or 8'h4B (DATA1); tx_valid = 1.
  - On accept, go to FETCH.
- FETCH:
  - If counter == MAX_PKT or usb_send_queue_empty, go to CRC_LO.
  - Otherwise pulse usb_send_queue_r_en for exactly one cycle and go to WAIT.
- WAIT:
  - Capture usb_send_queue_data_out into the holding register, fold it into the CRC, increment the counter, go to DATA.
- DATA:
  - Present the holding register with tx_valid = 1.
  - On accept, go to FETCH.
- CRC:
  - Polynomial x^16+x^15+x^2+1, reflected (0xA001 shift-right form), init 16'hFFFF.
  - Transmitted value is ~crc.
  - CRC_LO sends ~crc[7:0]; CRC_HI sends ~crc[15:8] with tx_last = 1.
- DONE:
  - One cycle: pkt_done = 1; pkt_bytes = counter; pkt_short = (counter < MAX_PKT).
  - busy drops; return to IDLE.
- Handshake rules:
  - tx_data, tx_valid and tx_last are registered and must stay stable while tx_valid && !tx_ready.
  - tx_valid is never withdrawn without an accept.
- Zero-length packet: queue empty at first FETCH gives PID, 8'h00, 8'h00, with pkt_bytes = 0 and pkt_short = 1.
- Exactly MAX_PKT bytes: pkt_short = 0. The next start produces the ZLP when the queue is empty.
- Queue emptiness is sampled only in FETCH. Bytes written after the decision go to the next packet.
- At most one outstanding read; usb_send_queue_r_en is never asserted while the queue is empty.
- pkt_bytes and pkt_short hold their values until the next DONE.

Optional Feature:
- Macro USB_DATA_TX_RETRY_EN.
- When defined:
  - Adds input retry (1 bit) and a MAX_PKT x 8 replay buffer written in WAIT.
  - start with retry = 1 resends the last packet: same PID, same payload from the buffer, same count, no queue reads.
  - start with retry = 1 before any packet has been sent produces a ZLP.
- When undefined:
  - No port, no buffer.
  - Every start reads fresh data from the queue; lost packets are the host's problem.

Decomposition:
- Shared package/header usb_defs: PID constants (PID_DATA0 = 8'hC3, PID_DATA1 = 8'h4B), CRC16_INIT = 16'hFFFF, CRC16_POLY_REFL = 16'hA001, FSM state encodings.
- One sub-module, usb_crc16: combinational byte-wise update, crc_next = f(crc, byte). It is reused by the receive-side CRC checker.

Test Plan:
- Queue holds 12 01 00 02 00 00 00 08, MAX_PKT = 8, toggle = 1, tx_ready = 1 → stream 4B 12 01 00 02 00 00 00 08 + CRC matching the bench reference model; pkt_bytes = 8, pkt_short = 0.
- Empty queue, toggle = 0 → C3 00 00, tx_last on the third byte, pkt_short = 1, no r_en pulses.
- 10 bytes queued, MAX_PKT = 8 → first start sends 8 bytes (pkt_short = 0); second start sends 2 bytes (pkt_short = 1); correct PID each time; total r_en count = 10.
- tx_ready randomly low 50% → byte sequence identical to the tx_ready = 1 run; tx_data stable during every stall.
- rst asserted mid-DATA → all outputs 0 in the same cycle; next start gives a clean packet from the remaining queue contents.
- (RETRY_EN) send 3 bytes, then start with retry = 1 → identical 3-byte packet and CRC, zero queue reads.
